// File: rtl/run_ctl_pkg.sv
// Shared types and default widths for the run-control / fetch sequencer.
package run_ctl_pkg;

  localparam int D_DEF  = 12;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

endpackage

// File: rtl/run_ctl_if.sv
// Bundle between run_ctl and its surroundings: host req/done handshake,
// decoder/ALU control inputs and the fetch/flag/status outputs.
interface run_ctl_if
  import run_ctl_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int CW = CW_DEF
);

  logic          req;
  logic          done;
  logic          halt;
  logic          branch_en;
  logic          jump_en;
  logic [D-1:0]  target;
  logic          zero;
  logic          sc_o;
  logic          sc_clr;
  logic          sc_en;
  logic [D-1:0]  prog_ctr;
  logic          zero_q;
  logic          sc_in;
  logic          run_en;
  logic [CW-1:0] cycle_cnt;
  logic          timeout;

  // Host / core side.
  modport master (
    output req, halt, branch_en, jump_en, target, zero, sc_o, sc_clr, sc_en,
    input  done, prog_ctr, zero_q, sc_in, run_en, cycle_cnt, timeout
  );

  // Sequencer side.
  modport slave (
    input  req, halt, branch_en, jump_en, target, zero, sc_o, sc_clr, sc_en,
    output done, prog_ctr, zero_q, sc_in, run_en, cycle_cnt, timeout
  );

endinterface

// File: rtl/run_ctl_pc_next.sv
// Combinational next-PC selector: halt > jump > taken branch > increment.
// All arithmetic wraps modulo 2**D.
module pc_next #(
  parameter int D      = 12,
  parameter bit BR_REL = 1'b1
) (
  input  logic [D-1:0] pc,
  input  logic         halt,
  input  logic         jump_en,
  input  logic         branch_en,
  input  logic         zero_q,
  input  logic [D-1:0] target,
  output logic [D-1:0] pc_nxt
);

  // Priority select of the next instruction address.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    pc_nxt = pc + D'(1);
    if (halt) begin
      pc_nxt = pc;
    end else if (jump_en) begin
      pc_nxt = target;
    end else if (branch_en && zero_q) begin
      pc_nxt = BR_REL ? (pc + target) : target;
    end
  end

endmodule

// File: rtl/run_ctl.sv
// Run-control and fetch sequencer for the 9-bit-ISA core: PC, zero and
// shift/carry flags, four-phase req/done handshake and cycle counter.
// Optional watchdog enabled by defining WDOG_EN.
module run_ctl
  import run_ctl_pkg::*;
#(
  parameter int D          = D_DEF,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 128,
  parameter bit BR_REL     = 1'b1,
  parameter int CW         = CW_DEF,
  parameter int MAX_CYC    = 16'hFFFF
) (
  input logic     clk,
  input logic     reset,
  run_ctl_if.slave bus
);

  localparam logic [D-1:0] START_PC = D'(START_ADDR);
  localparam logic [D-1:0] END_PC   = D'(END_ADDR);

  run_state_t    state, state_nxt;
  logic [D-1:0]  pc_q, pc_nxt;
  logic          zero_q, sc_q, done_q, timeout_q;
  logic [CW-1:0] cnt_q;
  logic          end_hit, wdog_hit, run_exit;

  pc_next #(.D(D), .BR_REL(BR_REL)) u_pc_next (
    .pc        (pc_q),
    .halt      (bus.halt),
    .jump_en   (bus.jump_en),
    .branch_en (bus.branch_en),
    .zero_q    (zero_q),
    .target    (bus.target),
    .pc_nxt    (pc_nxt)
  );

  assign end_hit = (pc_nxt == END_PC);

`ifdef WDOG_EN
  assign wdog_hit = (cnt_q == CW'(MAX_CYC));
`else
  assign wdog_hit = 1'b0;
`endif

  assign run_exit = bus.halt || end_hit || wdog_hit;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req)  state_nxt = RUN;
      RUN:     if (run_exit) state_nxt = DONE;
      DONE:    if (!bus.req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // PC, flags, counter and handshake registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= START_PC;
      zero_q    <= 1'b0;
      sc_q      <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc_q <= START_PC;
          if (bus.req) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
          end
        end
        RUN: begin
          zero_q <= bus.zero;
          if (bus.sc_clr)     sc_q <= 1'b0;
          else if (bus.sc_en) sc_q <= bus.sc_o;
          // A watchdog stop freezes PC and count at the limit.
          if (!wdog_hit) begin
            pc_q <= pc_nxt;
            if (cnt_q != '1) cnt_q <= cnt_q + CW'(1);
          end
          if (run_exit) begin
            done_q    <= 1'b1;
            timeout_q <= wdog_hit;
          end
        end
        DONE: begin
          if (!bus.req) begin
            done_q <= 1'b0;
            pc_q   <= START_PC;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.prog_ctr  = pc_q;
  assign bus.zero_q    = zero_q;
  assign bus.sc_in     = sc_q;
  assign bus.done      = done_q;
  assign bus.cycle_cnt = cnt_q;
  assign bus.timeout   = timeout_q;
  assign bus.run_en    = (state == RUN);

endmodule

// File: tb/tb_run_ctl.sv
// Bench for run_ctl: a cycle model of the default configuration checked
// every cycle, plus directed literal checks on three parameterisations.
module tb_run_ctl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // A: defaults. B: 4-bit PC with wrap, absolute branches. C: small counter for watchdog/saturation.
  run_ctl_if #(.D(12), .CW(16)) a_if();
  run_ctl_if #(.D(4),  .CW(8))  b_if();
  run_ctl_if #(.D(8),  .CW(4))  c_if();

  run_ctl #(.D(12), .START_ADDR(0), .END_ADDR(128), .BR_REL(1'b1), .CW(16), .MAX_CYC(16'hFFFF))
    dut_a (.clk(clk), .reset(reset), .bus(a_if));
  run_ctl #(.D(4), .START_ADDR(14), .END_ADDR(3), .BR_REL(1'b0), .CW(8), .MAX_CYC(255))
    dut_b (.clk(clk), .reset(reset), .bus(b_if));
  run_ctl #(.D(8), .START_ADDR(0), .END_ADDR(200), .BR_REL(1'b1), .CW(4), .MAX_CYC(10))
    dut_c (.clk(clk), .reset(reset), .bus(c_if));

  // Behavioural model of instance A.
  bit m_valid = 1'b0;
  bit m_busy, m_fin, m_z, m_sc, m_to;
  int m_pc, m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b1;
      m_busy = 0; m_fin = 0; m_z = 0; m_sc = 0; m_to = 0;
      m_pc = 0; m_cnt = 0;
    end else if (m_busy) begin
      int nxt;
      bit wd;
`ifdef WDOG_EN
      wd = (m_cnt == 16'hFFFF);
`else
      wd = 1'b0;
`endif
      if (a_if.halt)                     nxt = m_pc;
      else if (a_if.jump_en)             nxt = int'(a_if.target);
      else if (a_if.branch_en && m_z)    nxt = (m_pc + int'(a_if.target)) % 4096;
      else                               nxt = (m_pc + 1) % 4096;
      m_z = a_if.zero;
      if (a_if.sc_clr)     m_sc = 1'b0;
      else if (a_if.sc_en) m_sc = a_if.sc_o;
      if (!wd) begin
        m_pc  = nxt;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end
      if (a_if.halt || nxt == 128 || wd) begin
        m_busy = 0; m_fin = 1; m_to = wd;
      end
    end else if (m_fin) begin
      if (!a_if.req) begin m_fin = 0; m_pc = 0; end
    end else begin
      m_pc = 0;
      if (a_if.req) begin m_busy = 1; m_cnt = 0; m_to = 0; end
    end
  end

  // Per-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    if (!reset && m_valid) begin
      check("a.prog_ctr",  32'(a_if.prog_ctr),  32'(m_pc));
      check("a.done",      32'(a_if.done),      32'(m_fin));
      check("a.run_en",    32'(a_if.run_en),    32'(m_busy));
      check("a.cycle_cnt", 32'(a_if.cycle_cnt), 32'(m_cnt));
      check("a.zero_q",    32'(a_if.zero_q),    32'(m_z));
      check("a.sc_in",     32'(a_if.sc_in),     32'(m_sc));
      check("a.timeout",   32'(a_if.timeout),   32'(m_to));
    end
  end

  task automatic a_idle_inputs();
    a_if.halt = 0; a_if.branch_en = 0; a_if.jump_en = 0; a_if.target = '0;
    a_if.zero = 0; a_if.sc_o = 0; a_if.sc_clr = 0; a_if.sc_en = 0;
  endtask

  initial begin
    int b_pcs [5] = '{14, 15, 0, 1, 2};
    bit ok;
    int n;

    a_if.req = 0; a_idle_inputs();
    b_if.req = 0; b_if.halt = 0; b_if.branch_en = 0; b_if.jump_en = 0; b_if.target = '0;
    b_if.zero = 0; b_if.sc_o = 0; b_if.sc_clr = 0; b_if.sc_en = 0;
    c_if.req = 0; c_if.halt = 0; c_if.branch_en = 0; c_if.jump_en = 0; c_if.target = '0;
    c_if.zero = 0; c_if.sc_o = 0; c_if.sc_clr = 0; c_if.sc_en = 0;

    repeat (3) tick();
    reset = 0;
    tick();
    check("reset.prog_ctr",  32'(a_if.prog_ctr), 32'd0);
    check("reset.done",      32'(a_if.done), 32'd0);
    check("reset.run_en",    32'(a_if.run_en), 32'd0);
    check("reset.cycle_cnt", 32'(a_if.cycle_cnt), 32'd0);
    check("reset.b_pc",      32'(b_if.prog_ctr), 32'd14);

    // 1: straight run to END_ADDR.
    a_if.req = 1;
    ok = 0; n = 0;
    for (int i = 0; i < 200; i++) begin
      tick(); n++;
      if (a_if.done) begin ok = 1; break; end
    end
    check("t1.done_seen", 32'(ok), 32'd1);
    check("t1.latency",   32'(n), 32'd129);
    check("t1.prog_ctr",  32'(a_if.prog_ctr), 32'd128);
    check("t1.cycle_cnt", 32'(a_if.cycle_cnt), 32'd128);
    a_if.req = 0;
    tick();
    check("t1.idle_done", 32'(a_if.done), 32'd0);
    check("t1.idle_pc",   32'(a_if.prog_ctr), 32'd0);

    // 2: relative branch on registered zero.
    a_if.req = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_if.run_en && a_if.prog_ctr == 12'd5) begin ok = 1; break; end
    end
    check("t2.reach_pc5", 32'(ok), 32'd1);
    a_if.zero = 1; tick();
    a_if.zero = 0; a_if.branch_en = 1; a_if.target = 12'hFFE; tick();
    check("t2.branch_taken", 32'(a_if.prog_ctr), 32'd4);
    a_if.branch_en = 0; tick();
    tick();
    a_if.branch_en = 1; tick();
    check("t2.branch_not_taken", 32'(a_if.prog_ctr), 32'd7);

    // 3: jump beats branch; halt beats jump.
    a_if.branch_en = 0; a_if.zero = 1; tick();
    a_if.zero = 0; a_if.jump_en = 1; a_if.target = 12'd40; a_if.branch_en = 1; tick();
    check("t3.jump_prio", 32'(a_if.prog_ctr), 32'd40);
    a_if.jump_en = 0; a_if.branch_en = 0; tick();
    a_if.halt = 1; a_if.jump_en = 1; a_if.target = 12'd40; tick();
    check("t3.halt_pc",   32'(a_if.prog_ctr), 32'd41);
    check("t3.halt_done", 32'(a_if.done), 32'd1);
    a_idle_inputs(); tick();
    check("t3.no_restart", 32'(a_if.done), 32'd1);
    a_if.req = 0; tick();

    // 5: shift/carry flag, req drop ignored, reset mid-run.
    a_if.req = 1; tick();
    a_if.req = 0;
    a_if.sc_en = 1; a_if.sc_o = 1; tick();
    check("t5.sc_load", 32'(a_if.sc_in), 32'd1);
    a_if.sc_clr = 1; tick();
    check("t5.sc_clr_wins", 32'(a_if.sc_in), 32'd0);
    a_if.sc_clr = 0; tick();
    a_if.sc_en = 0; a_if.sc_o = 0; a_if.zero = 1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_if.prog_ctr == 12'd20) begin ok = 1; break; end
    end
    check("t5.reach_pc20", 32'(ok), 32'd1);
    check("t5.run_after_req_drop", 32'(a_if.run_en), 32'd1);
    reset = 1; #1;
    check("t5.rst_pc",     32'(a_if.prog_ctr), 32'd0);
    check("t5.rst_zero_q", 32'(a_if.zero_q), 32'd0);
    check("t5.rst_sc_in",  32'(a_if.sc_in), 32'd0);
    check("t5.rst_done",   32'(a_if.done), 32'd0);
    check("t5.rst_run_en", 32'(a_if.run_en), 32'd0);
    a_idle_inputs();
    tick(); reset = 0; tick();

    // END_ADDR reached by a jump.
    a_if.req = 1; tick();
    a_if.jump_en = 1; a_if.target = 12'd128; tick();
    check("jend.done", 32'(a_if.done), 32'd1);
    check("jend.pc",   32'(a_if.prog_ctr), 32'd128);
    a_idle_inputs(); a_if.req = 0; tick();

    // 4: 4-bit PC wraps silently from 15 to 0.
    b_if.req = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t4.pc%0d", i), 32'(b_if.prog_ctr), 32'(b_pcs[i]));
    end
    tick();
    check("t4.done",      32'(b_if.done), 32'd1);
    check("t4.end_pc",    32'(b_if.prog_ctr), 32'd3);
    check("t4.cycle_cnt", 32'(b_if.cycle_cnt), 32'd5);

    // 6: jump-to-self loop against the watchdog / saturating counter.
    c_if.req = 1; c_if.jump_en = 1; c_if.target = 8'd0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (c_if.done) begin ok = 1; break; end
    end
`ifdef WDOG_EN
    check("t6.wdog_done",    32'(ok), 32'd1);
    check("t6.wdog_timeout", 32'(c_if.timeout), 32'd1);
    check("t6.wdog_cnt",     32'(c_if.cycle_cnt), 32'd10);
    check("t6.wdog_pc",      32'(c_if.prog_ctr), 32'd0);
`else
    check("t6.no_end",    32'(ok), 32'd0);
    check("t6.still_run", 32'(c_if.run_en), 32'd1);
    check("t6.saturate",  32'(c_if.cycle_cnt), 32'hF);
    check("t6.timeout0",  32'(c_if.timeout), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
